exe_stage: RTL and testbench

Execute stage of the 5-stage ARM-subset pipeline. It consumes the ID/EX pipeline register outputs, forms the second operand, runs the ALU, and keeps the NZCV status register. It drives branch target/taken back to IF and the condition-check logic in ID, and it registers results into the EX/MEM pipeline register.

---
 rtl/exe_stage.sv | 145 ++++++++++++++
 tb/tb_exe_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// Execute stage: operand-2 shifter, ALU with NZCV flags, branch target, EX/MEM register.
// Branch outputs are combinational; everything else is registered.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic [31:0] pc_in,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic        b_in,
  input  logic        s_in,
  input  logic [3:0]  exe_cmd_in,
  input  logic [31:0] val_rn_in,
  input  logic [31:0] val_rm_in,
  input  logic        imm_in,
  input  logic [11:0] shift_operand_in,
  input  logic [23:0] signed_imm_24_in,
  input  logic [3:0]  dest_in,
  output logic        branch_taken,
  output logic [31:0] branch_addr,
  output logic [3:0]  status,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic        mem_w_en_out,
  output logic [31:0] alu_res_out,
  output logic [31:0] val_rm_out,
  output logic [3:0]  dest_out
);

  localparam int unsigned DW = 32;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  function automatic logic [DW-1:0] ror32(input logic [DW-1:0] x, input logic [4:0] n);
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  logic [DW-1:0] val2;
  logic [4:0]    shift_amt;

  assign shift_amt = shift_operand_in[11:7];

  // Memory offset wins over immediate, which wins over shifted register
  always_comb begin
    val2 = '0;
    if (mem_r_en_in || mem_w_en_in) begin
      val2 = {{20{shift_operand_in[11]}}, shift_operand_in};
    end else if (imm_in) begin
      val2 = ror32({24'b0, shift_operand_in[7:0]}, {shift_operand_in[11:8], 1'b0});
    end else begin
      case (shift_operand_in[6:5])
        2'b00:   val2 = val_rm_in << shift_amt;
        2'b01:   val2 = val_rm_in >> shift_amt;
        2'b10:   val2 = DW'($signed(val_rm_in) >>> shift_amt);
        default: val2 = ror32(val_rm_in, shift_amt);
      endcase
    end
  end

  logic          add_cin;
  logic          sub_borrow;
  logic [DW:0]   add_full;
  logic [DW:0]   sub_full;
  logic          add_ovf;
  logic          sub_ovf;

  assign add_cin    = (exe_cmd_in == CMD_ADC) & status[1];
  assign sub_borrow = (exe_cmd_in == CMD_SBC) & ~status[1];
  assign add_full   = {1'b0, val_rn_in} + {1'b0, val2} + 33'(add_cin);
  assign sub_full   = {1'b0, val_rn_in} - {1'b0, val2} - 33'(sub_borrow);
  assign add_ovf    = (val_rn_in[31] == val2[31]) && (add_full[31] != val_rn_in[31]);
  assign sub_ovf    = (val_rn_in[31] != val2[31]) && (sub_full[31] != val_rn_in[31]);

  logic [DW-1:0] alu_res;
  logic          c_next;
  logic          v_next;
  logic [3:0]    flags_next;

  // Unlisted commands yield zero and keep C/V
  always_comb begin
    alu_res = '0;
    c_next  = status[1];
    v_next  = status[0];
    case (exe_cmd_in)
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      CMD_ADD, CMD_ADC: begin
        alu_res = add_full[DW-1:0];
        c_next  = add_full[DW];
        v_next  = add_ovf;
      end
      CMD_SUB, CMD_SBC: begin
        alu_res = sub_full[DW-1:0];
        c_next  = ~sub_full[DW];
        v_next  = sub_ovf;
      end
      CMD_AND: alu_res = val_rn_in & val2;
      CMD_ORR: alu_res = val_rn_in | val2;
      CMD_EOR: alu_res = val_rn_in ^ val2;
      default: alu_res = '0;
    endcase
  end

  assign flags_next = {alu_res[DW-1], (alu_res == '0), c_next, v_next};

  assign branch_taken = b_in;
  assign branch_addr  = pc_in + {{6{signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status <= '0;
    end else if (s_in && !freeze) begin
      status <= flags_next;
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      mem_w_en_out <= 1'b0;
      alu_res_out  <= '0;
      val_rm_out   <= '0;
      dest_out     <= '0;
    end else if (!freeze) begin
      wb_en_out    <= wb_en_in;
      mem_r_en_out <= mem_r_en_in;
      mem_w_en_out <= mem_w_en_in;
      alu_res_out  <= alu_res;
      val_rm_out   <= val_rm_in;
      dest_out     <= dest_in;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed vector table, hand sequences for reset/freeze/branch,
// and a randomized run against an arithmetic reference model.
module tb_exe_stage;

  logic        clk, rst, freeze;
  logic [31:0] pc_in;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in;
  logic [3:0]  exe_cmd_in;
  logic [31:0] val_rn_in, val_rm_in;
  logic        imm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [3:0]  dest_in;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  status;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out;
  logic [31:0] alu_res_out, val_rm_out;
  logic [3:0]  dest_out;

  int n_cmp = 0;
  int n_err = 0;

  exe_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .pc_in(pc_in),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .dest_in(dest_in), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .status(status), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .alu_res_out(alu_res_out),
    .val_rm_out(val_rm_out), .dest_out(dest_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  cmd;
    logic        s, imm, mr, mw;
    logic [31:0] rn, rm;
    logic [11:0] sop;
    logic [31:0] exp_res;
    logic [3:0]  exp_st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] cmd, input logic s, imm, mr, mw,
                              input logic [31:0] rn, rm, input logic [11:0] sop,
                              input logic [31:0] res, input logic [3:0] st);
    vec_t v;
    v.cmd = cmd; v.s = s; v.imm = imm; v.mr = mr; v.mw = mw;
    v.rn = rn; v.rm = rm; v.sop = sop; v.exp_res = res; v.exp_st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] cmd, input logic s, imm, mr, mw,
                       input logic [31:0] rn, rm, input logic [11:0] sop,
                       input logic [3:0] dst);
    exe_cmd_in = cmd; s_in = s; imm_in = imm; mem_r_en_in = mr; mem_w_en_in = mw;
    wb_en_in = !mw; val_rn_in = rn; val_rm_in = rm; shift_operand_in = sop; dest_in = dst;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_res"}, alu_res_out, 32'h0);
    chk({tag, "_status"}, 32'(status), 32'h0);
    chk({tag, "_ctl"}, 32'({wb_en_out, mem_r_en_out, mem_w_en_out}), 32'h0);
    chk({tag, "_rm"}, val_rm_out, 32'h0);
    chk({tag, "_dest"}, 32'(dest_out), 32'h0);
  endtask

  // Reference model: shifts and rotates as multiply/divide by powers of two
  function automatic logic [31:0] ror_ref(input logic [31:0] x, input int n);
    longint p, ux;
    p  = longint'(1) << n;
    ux = longint'(x);
    return 32'((ux / p) + (ux % p) * (longint'(1) << (32 - n)));
  endfunction

  function automatic logic [31:0] val2_ref(input logic mr, mw, imm, input logic [11:0] sop,
                                           input logic [31:0] rm);
    int n;
    longint p, ux, sx;
    if (mr || mw) return 32'(sop[11] ? longint'(sop) - 4096 : longint'(sop));
    if (imm) return ror_ref({24'b0, sop[7:0]}, 2 * int'(sop[11:8]));
    n  = int'(sop[11:7]);
    p  = longint'(1) << n;
    ux = longint'(rm);
    sx = longint'($signed(rm));
    case (sop[6:5])
      2'b00:   return 32'(ux * p);
      2'b01:   return 32'(ux / p);
      2'b10:   return 32'((sx >= 0) ? sx / p : -((-sx + p - 1) / p));
      default: return ror_ref(rm, n);
    endcase
  endfunction

  function automatic logic ovf(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic alu_ref(input logic [3:0] cmd, input logic [31:0] rn, v2,
                         input logic [3:0] st_in, output logic [31:0] res,
                         output logic [3:0] st_out);
    longint ur, uv, sr, sv, full, ci;
    logic c, v;
    ur = longint'(rn); uv = longint'(v2);
    sr = longint'($signed(rn)); sv = longint'($signed(v2));
    c = st_in[1]; v = st_in[0];
    case (cmd)
      4'd1: res = v2;
      4'd9: res = ~v2;
      4'd2, 4'd3: begin
        ci   = (cmd == 4'd3) ? longint'(st_in[1]) : 0;
        full = ur + uv + ci;
        res  = 32'(full);
        c    = full >= (longint'(1) << 32);
        v    = ovf(sr + sv + ci);
      end
      4'd4, 4'd5: begin
        ci   = (cmd == 4'd5) ? longint'(!st_in[1]) : 0;
        full = ur - uv - ci;
        res  = 32'(full);
        c    = full >= 0;
        v    = ovf(sr - sv - ci);
      end
      4'd6: res = rn & v2;
      4'd7: res = rn | v2;
      4'd8: res = rn ^ v2;
      default: res = 32'h0;
    endcase
    st_out = {res[31], res == 32'h0, c, v};
  endtask

  logic [31:0] m_res, m_rm, v2, r;
  logic [3:0]  m_st, m_dest, st_new;
  logic [2:0]  m_ctl;
  longint      off;

  initial begin
    rst = 1'b1; freeze = 1'b0; pc_in = '0; b_in = 1'b0; signed_imm_24_in = '0;
    drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 12'h0, 4'h0);
    tick; tick;
    chk_all_zero("reset");
    rst = 1'b0;

    // cmd s imm mr mw rn rm sop exp_res exp_status (status carries across rows)
    vecs.push_back(mk(4'd4, 1, 1, 0, 0, 32'h5,        32'h0,        12'h005, 32'h0,        4'b0110));
    vecs.push_back(mk(4'd4, 1, 1, 0, 0, 32'h0,        32'h0,        12'h001, 32'hFFFFFFFF, 4'b1000));
    vecs.push_back(mk(4'd2, 1, 1, 0, 0, 32'h7FFFFFFF, 32'h0,        12'h001, 32'h80000000, 4'b1001));
    vecs.push_back(mk(4'd15,1, 1, 0, 0, 32'h123,      32'h0,        12'h077, 32'h0,        4'b0101));
    vecs.push_back(mk(4'd3, 1, 1, 0, 0, 32'h0,        32'h0,        12'h000, 32'h0,        4'b0100));
    vecs.push_back(mk(4'd1, 0, 0, 0, 0, 32'h0,        32'h80000001, 12'h0C0, 32'hC0000000, 4'b0100));
    vecs.push_back(mk(4'd1, 0, 0, 0, 0, 32'h0,        32'h80000001, 12'h0E0, 32'hC0000000, 4'b0100));
    vecs.push_back(mk(4'd1, 0, 0, 0, 0, 32'h0,        32'h80000001, 12'h0A0, 32'h40000000, 4'b0100));
    vecs.push_back(mk(4'd1, 0, 1, 0, 0, 32'h0,        32'h0,        12'h4FF, 32'hFF000000, 4'b0100));
    vecs.push_back(mk(4'd1, 0, 0, 0, 0, 32'h0,        32'h1,        12'h200, 32'h10,       4'b0100));
    vecs.push_back(mk(4'd2, 0, 0, 1, 0, 32'h100,      32'hDEADBEEF, 12'hFFC, 32'hFC,       4'b0100));
    vecs.push_back(mk(4'd4, 1, 1, 0, 0, 32'h5,        32'h0,        12'h005, 32'h0,        4'b0110));
    vecs.push_back(mk(4'd5, 1, 1, 0, 0, 32'hA,        32'h0,        12'h003, 32'h7,        4'b0010));
    vecs.push_back(mk(4'd3, 1, 1, 0, 0, 32'hFFFFFFFF, 32'h0,        12'h001, 32'h1,        4'b0010));
    vecs.push_back(mk(4'd9, 1, 1, 0, 0, 32'h0,        32'h0,        12'h000, 32'hFFFFFFFF, 4'b1010));
    vecs.push_back(mk(4'd6, 1, 0, 0, 0, 32'hF0F0,     32'h0FF0,     12'h000, 32'h00F0,     4'b0010));
    vecs.push_back(mk(4'd7, 0, 0, 0, 0, 32'hF000,     32'h000F,     12'h000, 32'hF00F,     4'b0010));
    vecs.push_back(mk(4'd8, 1, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 12'h000, 32'h0,        4'b0110));
    vecs.push_back(mk(4'd4, 1, 1, 0, 0, 32'h80000000, 32'h0,        12'h001, 32'h7FFFFFFF, 4'b0011));
    vecs.push_back(mk(4'd5, 1, 1, 0, 0, 32'h0,        32'h0,        12'h000, 32'h0,        4'b0110));
    vecs.push_back(mk(4'd2, 0, 0, 0, 1, 32'h200,      32'h0000CAFE, 12'h004, 32'h204,      4'b0110));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].cmd, vecs[i].s, vecs[i].imm, vecs[i].mr, vecs[i].mw,
            vecs[i].rn, vecs[i].rm, vecs[i].sop, 4'(i));
      tick;
      chk($sformatf("vec%0d_res", i), alu_res_out, vecs[i].exp_res);
      chk($sformatf("vec%0d_status", i), 32'(status), 32'(vecs[i].exp_st));
      chk($sformatf("vec%0d_ctl", i), 32'({wb_en_out, mem_r_en_out, mem_w_en_out}),
          32'({!vecs[i].mw, vecs[i].mr, vecs[i].mw}));
      chk($sformatf("vec%0d_rm", i), val_rm_out, vecs[i].rm);
      chk($sformatf("vec%0d_dest", i), 32'(dest_out), 32'(i[3:0]));
    end

    // Branch target is combinational
    pc_in = 32'h20; signed_imm_24_in = 24'hFFFFFE; b_in = 1'b1;
    #1;
    chk("br_back_addr", branch_addr, 32'h18);
    chk("br_taken", 32'(branch_taken), 32'h1);
    pc_in = 32'h100; signed_imm_24_in = 24'h000010; b_in = 1'b0;
    #1;
    chk("br_fwd_addr", branch_addr, 32'h140);
    chk("br_not_taken", 32'(branch_taken), 32'h0);
    tick;

    // Freeze holds pipeline register and status even with s_in set
    drive(4'd2, 1, 1, 0, 0, 32'h7FFFFFFF, 32'h0, 12'h001, 4'd3);
    tick;
    chk("frz_pre_res", alu_res_out, 32'h80000000);
    chk("frz_pre_status", 32'(status), 32'h9);
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(4'd4, 1, 1, 0, 0, 32'h5, $urandom, 12'h005, 4'(k + 8));
      tick;
      chk($sformatf("frz%0d_res", k), alu_res_out, 32'h80000000);
      chk($sformatf("frz%0d_status", k), 32'(status), 32'h9);
      chk($sformatf("frz%0d_dest", k), 32'(dest_out), 32'h3);
      chk($sformatf("frz%0d_rm", k), val_rm_out, 32'h0);
    end
    freeze = 1'b0;
    tick;
    chk("unfrz_res", alu_res_out, 32'h0);
    chk("unfrz_status", 32'(status), 32'h6);
    chk("unfrz_dest", 32'(dest_out), 32'hA);

    // Asynchronous reset in the middle of a cycle
    drive(4'd1, 1, 0, 0, 0, 32'h0, 32'h1234, 12'h000, 4'd7);
    tick;
    chk("prerst_res", alu_res_out, 32'h1234);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    tick;
    rst = 1'b0;
    #1;
    chk_all_zero("post_rst");
    tick;
    chk("first_capture_res", alu_res_out, 32'h1234);
    chk("first_capture_dest", 32'(dest_out), 32'h7);

    // Randomized run against the reference model
    m_st = status;
    m_res = alu_res_out; m_rm = val_rm_out; m_dest = dest_out;
    m_ctl = {wb_en_out, mem_r_en_out, mem_w_en_out};
    for (int i = 0; i < 300; i++) begin
      drive(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom, $urandom, 12'($urandom), 4'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        val_rn_in = 32'h7FFFFFFF + 32'($urandom_range(0, 2));
        val_rm_in = {1'($urandom), 31'h0};
      end
      freeze = ($urandom_range(0, 7) == 0);
      pc_in = $urandom; signed_imm_24_in = 24'($urandom); b_in = 1'($urandom);
      #1;
      off = signed_imm_24_in[23] ? longint'(signed_imm_24_in) - (longint'(1) << 24)
                                 : longint'(signed_imm_24_in);
      chk("rnd_br_addr", branch_addr, 32'(longint'(pc_in) + 4 * off));
      v2 = val2_ref(mem_r_en_in, mem_w_en_in, imm_in, shift_operand_in, val_rm_in);
      alu_ref(exe_cmd_in, val_rn_in, v2, m_st, r, st_new);
      if (!freeze) begin
        m_res = r; m_rm = val_rm_in; m_dest = dest_in;
        m_ctl = {wb_en_in, mem_r_en_in, mem_w_en_in};
        if (s_in) m_st = st_new;
      end
      tick;
      chk($sformatf("rnd%0d_res cmd=%h", i, exe_cmd_in), alu_res_out, m_res);
      chk($sformatf("rnd%0d_status", i), 32'(status), 32'(m_st));
      chk($sformatf("rnd%0d_ctl", i), 32'({wb_en_out, mem_r_en_out, mem_w_en_out}), 32'(m_ctl));
      chk($sformatf("rnd%0d_rm", i), val_rm_out, m_rm);
      chk($sformatf("rnd%0d_dest", i), 32'(dest_out), 32'(m_dest));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
